// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IF/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rsp_tag_pipe.sv
// Owner-tag delay line: a tag entered at a grant exits exactly MEM_LATENCY cycles later,
// lined up with the memory read data.
module rsp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic   clock,
    input  logic   reset,
    input  owner_t tag_in,
    output owner_t tag_out
);

    owner_t pipe_q [MEM_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= OWN_NONE;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_out = pipe_q[MEM_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency memory between instruction fetch and data ports, with data
// priority, an IF starvation guard, and owner tags routing read responses back.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          if_req,
    input  logic [ADDR_W-1:0]             if_addr,
    output logic                          if_gnt,
    output logic                          if_rvalid,
    output logic [DATA_W-1:0]             if_rdata,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [be_width(DATA_W)-1:0]   d_be,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic                          d_gnt,
    output logic                          d_rvalid,
    output logic [DATA_W-1:0]             d_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [be_width(DATA_W)-1:0]   mem_be,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int BE_W  = be_width(DATA_W);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q;
    logic             d_win;
    logic             if_win;
    owner_t           tag_in;
    owner_t           tag_out;

    // Data wins unless IF has been denied STARVE_MAX cycles in a row.
    always_comb begin
        d_win  = !reset && d_req && ((starve_q < CNT_W'(STARVE_MAX)) || !if_req);
        if_win = !reset && if_req && !d_win;
    end

    assign if_gnt  = if_win;
    assign d_gnt   = d_win;
    assign mem_req = if_win | d_win;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
        end else if (if_req && !if_win) begin
            if (starve_q != CNT_W'(STARVE_MAX)) begin
                starve_q <= starve_q + 1'b1;
            end
        end else begin
            starve_q <= '0;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_win) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_win) begin
            mem_be    = {BE_W{1'b1}};
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        tag_in = OWN_NONE;
        if (d_win) begin
            tag_in = d_we ? OWN_NONE : OWN_D;
        end else if (if_win) begin
            tag_in = OWN_IF;
        end
    end

    rsp_tag_pipe #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        if (!reset) begin
            unique case (tag_out)
                OWN_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                OWN_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (MEM_LATENCY 1, 2, 3) share stimulus, each with its own
// byte-enabled memory model whose read data is delayed by that instance's latency.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        if_gnt    [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata  [3];
    logic        d_gnt     [3];
    logic        d_rvalid  [3];
    logic [31:0] d_rdata   [3];
    logic        mem_req   [3];
    logic        mem_we    [3];
    logic [3:0]  mem_be    [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = g + 1;
        logic [31:0] mem [256];
        logic [31:0] rd_pipe [L];

        // Preload: word at byte address a holds 0x13 + a*0x20 below 0x200, zero above.
        initial begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = (i < 128) ? (32'h13 + 32'(i) * 32'h80) : 32'h0;
            end
        end

        always @(posedge clock) begin
            for (int k = L - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
            rd_pipe[0] <= 32'hA5A5_A5A5;
            if (mem_req[g]) begin
                if (mem_we[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[g][b]) mem[mem_addr[g][9:2]][b*8 +: 8] <= mem_wdata[g][b*8 +: 8];
                    end
                end else begin
                    rd_pipe[0] <= mem[mem_addr[g][9:2]];
                end
            end
        end

        assign mem_rdata[g] = rd_pipe[L-1];

        mem_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_LATENCY (L),
            .STARVE_MAX  (4)
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_be      (d_be),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_be    (mem_be[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a < 32'h200) ? (32'h13 + a * 32'h20) : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = '0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    task automatic drain(input int n);
        idle_inputs();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h40;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hF;
        d_addr  = 32'h44;
        d_wdata = 32'h1234_5678;
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            checks++; if (if_gnt[g] !== 1'b0 || d_gnt[g] !== 1'b0)
                $display("FAIL reset_gnt inst%0d: got if=%b d=%b want 0 0", g, if_gnt[g], d_gnt[g]);
            else passed++;
            checks++; if (mem_req[g] !== 1'b0 || mem_we[g] !== 1'b0 || mem_be[g] !== 4'h0)
                $display("FAIL reset_memctl inst%0d: got req=%b we=%b be=%h want 0", g, mem_req[g], mem_we[g], mem_be[g]);
            else passed++;
            checks++; if (mem_addr[g] !== 32'h0 || mem_wdata[g] !== 32'h0)
                $display("FAIL reset_memdata inst%0d: got addr=%h wdata=%h want 0", g, mem_addr[g], mem_wdata[g]);
            else passed++;
            checks++; if (if_rvalid[g] !== 1'b0 || d_rvalid[g] !== 1'b0 || if_rdata[g] !== 32'h0 || d_rdata[g] !== 32'h0)
                $display("FAIL reset_rsp inst%0d: got ifv=%b dv=%b ifd=%h dd=%h want 0", g, if_rvalid[g], d_rvalid[g], if_rdata[g], d_rdata[g]);
            else passed++;
        end
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_if_stream();
        logic [31:0] exp [3];
        exp = '{32'h13, 32'h93, 32'h113};
        for (int c = 0; c < 4; c++) begin
            if_req  = (c < 3);
            if_addr = 32'(4 * c);
            #1;
            if (c < 3) begin
                checks++; if (if_gnt[0] !== 1'b1 || mem_addr[0] !== 32'(4 * c) || mem_be[0] !== 4'hF || mem_we[0] !== 1'b0)
                    $display("FAIL if_stream_gnt c%0d: got gnt=%b addr=%h be=%h we=%b want 1 %h f 0", c, if_gnt[0], mem_addr[0], mem_be[0], mem_we[0], 4 * c);
                else passed++;
            end
            if (c > 0) begin
                checks++; if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== exp[c-1])
                    $display("FAIL if_stream_rsp c%0d: got v=%b data=%h want 1 %h", c, if_rvalid[0], if_rdata[0], exp[c-1]);
                else passed++;
            end else begin
                checks++; if (if_rvalid[0] !== 1'b0)
                    $display("FAIL if_stream_early c0: got v=%b want 0", if_rvalid[0]);
                else passed++;
            end
            tick();
        end
        drain(4);
    endtask

    task automatic test_collision();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        checks++; if (d_gnt[0] !== 1'b1 || if_gnt[0] !== 1'b0)
            $display("FAIL collide_c0: got d=%b if=%b want 1 0", d_gnt[0], if_gnt[0]);
        else passed++;
        tick();
        d_req = 1'b0;
        #1;
        checks++; if (if_gnt[0] !== 1'b1 || d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'h2013 || if_rvalid[0] !== 1'b0)
            $display("FAIL collide_c1: got ifg=%b dv=%b dd=%h ifv=%b want 1 1 2013 0", if_gnt[0], d_rvalid[0], d_rdata[0], if_rvalid[0]);
        else passed++;
        tick();
        if_req = 1'b0;
        #1;
        checks++; if (if_rvalid[0] !== 1'b1 || if_rdata[0] !== 32'h213 || d_rvalid[0] !== 1'b0)
            $display("FAIL collide_c2: got ifv=%b ifd=%h dv=%b want 1 213 0", if_rvalid[0], if_rdata[0], d_rvalid[0]);
        else passed++;
        drain(4);
    endtask

    task automatic test_starvation();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h20;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (d_gnt[0] !== (c != 4) || if_gnt[0] !== (c == 4))
                $display("FAIL starve c%0d: got d=%b if=%b want %b %b", c, d_gnt[0], if_gnt[0], c != 4, c == 4);
            else passed++;
            if (c == 4) begin
                checks++; if (mem_addr[0] !== 32'h20)
                    $display("FAIL starve_addr: got %h want 00000020", mem_addr[0]);
                else passed++;
            end
            tick();
            if (c == 4) if_req = 1'b0;
        end
        drain(4);
    endtask

    task automatic test_store_then_load();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (d_gnt[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_be[0] !== 4'b0011 || mem_wdata[0] !== 32'hDEAD_BEEF || mem_addr[0] !== 32'h200)
            $display("FAIL store_mux: got g=%b we=%b be=%b wd=%h a=%h want 1 1 0011 deadbeef 200", d_gnt[0], mem_we[0], mem_be[0], mem_wdata[0], mem_addr[0]);
        else passed++;
        tick();
        d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
        #1;
        checks++; if (d_rvalid[0] !== 1'b0 || d_gnt[0] !== 1'b1)
            $display("FAIL store_no_rvalid: got dv=%b g=%b want 0 1", d_rvalid[0], d_gnt[0]);
        else passed++;
        tick();
        d_req = 1'b0;
        #1;
        checks++; if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'h0000_BEEF)
            $display("FAIL store_load_back: got dv=%b dd=%h want 1 0000beef", d_rvalid[0], d_rdata[0]);
        else passed++;
        drain(4);
    endtask

    task automatic test_reset_midflight();
        if_req = 1'b1; if_addr = 32'h4;
        #1;
        checks++; if (if_gnt[1] !== 1'b1)
            $display("FAIL midrst_gnt: got %b want 1", if_gnt[1]);
        else passed++;
        tick();
        reset = 1'b1;
        #1;
        checks++; if (if_gnt[1] !== 1'b0 || mem_req[1] !== 1'b0 || mem_addr[1] !== 32'h0 || mem_be[1] !== 4'h0
                      || if_rvalid[1] !== 1'b0 || if_rdata[1] !== 32'h0)
            $display("FAIL midrst_zero: got g=%b mr=%b a=%h be=%h v=%b d=%h want all 0", if_gnt[1], mem_req[1], mem_addr[1], mem_be[1], if_rvalid[1], if_rdata[1]);
        else passed++;
        tick();
        reset = 1'b0; if_req = 1'b0;
        #1;
        checks++; if (if_rvalid[1] !== 1'b0 || if_rdata[1] !== 32'h0)
            $display("FAIL midrst_dropped: got v=%b d=%h want 0 0", if_rvalid[1], if_rdata[1]);
        else passed++;
        tick();
        if_req = 1'b1; if_addr = 32'h8;
        #1;
        checks++; if (if_gnt[1] !== 1'b1 || mem_addr[1] !== 32'h8)
            $display("FAIL midrst_regrant: got g=%b a=%h want 1 8", if_gnt[1], mem_addr[1]);
        else passed++;
        tick();
        if_req = 1'b0;
        tick();
        checks++; if (if_rvalid[1] !== 1'b1 || if_rdata[1] !== 32'h113)
            $display("FAIL midrst_rsp: got v=%b d=%h want 1 113", if_rvalid[1], if_rdata[1]);
        else passed++;
        drain(4);
    endtask

    task automatic test_alternating_lat3();
        for (int c = 0; c < 11; c++) begin
            if_req  = (c < 8) && (c % 2 == 0);
            if_addr = 32'(4 * c);
            d_req   = (c < 8) && (c % 2 == 1);
            d_we    = 1'b0;
            d_be    = 4'hF;
            d_addr  = 32'h100 + 32'(4 * c);
            #1;
            if (c < 8) begin
                checks++; if (if_gnt[2] !== (c % 2 == 0) || d_gnt[2] !== (c % 2 == 1))
                    $display("FAIL alt_gnt c%0d: got if=%b d=%b", c, if_gnt[2], d_gnt[2]);
                else passed++;
            end
            if (c >= 3 && (c - 3) % 2 == 0) begin
                checks++; if (if_rvalid[2] !== 1'b1 || if_rdata[2] !== word_at(32'(4 * (c - 3))) || d_rvalid[2] !== 1'b0)
                    $display("FAIL alt_if_rsp c%0d: got ifv=%b ifd=%h dv=%b want 1 %h 0", c, if_rvalid[2], if_rdata[2], d_rvalid[2], word_at(32'(4 * (c - 3))));
                else passed++;
            end else if (c >= 3) begin
                checks++; if (d_rvalid[2] !== 1'b1 || d_rdata[2] !== word_at(32'h100 + 32'(4 * (c - 3))) || if_rvalid[2] !== 1'b0)
                    $display("FAIL alt_d_rsp c%0d: got dv=%b dd=%h ifv=%b want 1 %h 0", c, d_rvalid[2], d_rdata[2], if_rvalid[2], word_at(32'h100 + 32'(4 * (c - 3))));
                else passed++;
            end else begin
                checks++; if (if_rvalid[2] !== 1'b0 || d_rvalid[2] !== 1'b0)
                    $display("FAIL alt_early c%0d: got ifv=%b dv=%b want 0 0", c, if_rvalid[2], d_rvalid[2]);
                else passed++;
            end
            tick();
        end
        drain(4);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        test_reset();
        test_if_stream();
        test_collision();
        test_starvation();
        test_store_then_load();
        test_reset_midflight();
        test_alternating_lat3();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the core's instruction-fetch (IF) port and its data (MEM-stage load/store) port.
- Arbitrates every cycle, with data priority and a starvation guard for IF.
- Tracks in-flight reads so each response is routed back to its owner.
- Sits between `core` and the memory model; the pipeline consumes the grants as stall conditions.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 wide.
- MEM_LATENCY, 1, cycles from an accepted memory request to valid mem_rdata; must be >= 1.
- STARVE_MAX, 4, number of consecutive denied IF cycles after which IF takes priority.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF read request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DATA_W  instruction word.
- d_req  in  1  data request; held with its attributes stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: d_rdata is valid (loads only).
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid exactly MEM_LATENCY cycles after the request.

Behaviour:
- Arbitration is combinational, from the current requests and starve_cnt.
  - At most one grant per cycle.
  - mem_req = if_gnt | d_gnt.
  - The memory samples on the same rising edge as the grant.
  - Requests are issued back-to-back; there is no bubble between grants.
- Priority:
  - If d_req and (starve_cnt < STARVE_MAX or !if_req): grant D.
  - Else if if_req: grant IF.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each cycle with if_req=1 and if_gnt=0.
  - Clears to 0 on if_gnt or when if_req=0.
- Mux:
  - On a D grant, mem_* take the d_* values.
  - On an IF grant: mem_addr=if_addr, mem_we=0, mem_be=all ones, mem_wdata=0.
  - With no grant: all mem_* outputs are 0.
- Tag pipeline:
  - A MEM_LATENCY-deep shift register of owner tags {NONE, IF, D}, shifting every cycle.
  - Tag entered: IF for an IF grant, D for a D load, NONE for stores and idle cycles.
  - When the exiting tag is IF: if_rvalid=1 and if_rdata=mem_rdata.
  - When the exiting tag is D: d_rvalid=1 and d_rdata=mem_rdata.
  - Otherwise both rvalid are 0 and both rdata are 0.
- Latency: a read granted in cycle N returns rvalid in cycle N+MEM_LATENCY. Responses are strictly in grant order.
- Stores:
  - Complete at the grant.
  - Never produce d_rvalid.
  - A store followed by a load to the same address in the next cycle returns the new data; memory ordering suffices.
- Reset:
  - Clears starve_cnt and all tags to NONE.
  - While reset=1, all grants, mem_req and rvalid outputs are 0, and all data outputs are 0.
  - Reset mid-operation drops in-flight reads: no rvalid appears after reset for requests granted before it.
- Simultaneous arrival when starve_cnt=STARVE_MAX: IF wins, starve_cnt clears, and D is granted the following cycle if still requesting.
- Requests dropped before being granted are legal and leave no state behind.

Decomposition:
- Package mem_arb_pkg:
  - owner_t enum (OWN_NONE, OWN_IF, OWN_D).
  - Default widths.
  - Byte-enable width function.
- Sub-module rsp_tag_pipe:
  - Parameterised MEM_LATENCY-deep owner-tag shift register.
  - Synchronous reset to OWN_NONE.
  - Outputs the exiting tag.
- Arbitration, starve counter and muxes stay in mem_arbiter.

Test Plan:
1. MEM_LATENCY=1, IF reads 0x0/0x4/0x8 back-to-back (memory preloaded 0x13,0x93,0x113) -> if_gnt=1 in cycles 0–2; if_rvalid in cycles 1–3 with if_rdata 0x13/0x93/0x113 in order.
2. Same-cycle d load 0x100 and IF 0x10 -> d_gnt in cycle 0, if_gnt in cycle 1; d_rvalid in cycle 1, if_rvalid in cycle 2, each carrying its own word.
3. d_req held for 10 cycles alongside if_req, STARVE_MAX=4 -> IF denied cycles 0–3, if_gnt in cycle 4 with d_gnt=0 there, D resumes in cycle 5.
4. d store addr 0x200, be=4'b0011, wdata 0xDEADBEEF -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; no d_rvalid; a following load of 0x200 returns 0x0000BEEF over zero-initialised memory.
5. MEM_LATENCY=2, IF read granted in cycle 0, reset=1 in cycle 1 -> no if_rvalid in cycle 2; all outputs 0 during reset; normal grants after release.
6. MEM_LATENCY=3, alternating IF/D loads over 8 cycles -> every rvalid appears 3 cycles after its grant on the correct port; no crossed data.
